// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/decode/execute control FSM for the MAX/MIN/AVG ASIP.
// Optional build macro SINGLE_STEP_EN adds a step input and a STEPWAIT state.
`timescale 1ns/1ps
`default_nettype none

module pc_sequencer #(
  parameter int AW   = 8,
  parameter int CNTW = 16
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            start,
`ifdef SINGLE_STEP_EN
  input  logic            step,
`endif
  output logic            mem_rd,
  input  logic            mem_valid,
  input  logic [7:0]      mem_data,
  output logic            pc_load,
  output logic            pc_inc,
  output logic [AW-1:0]   pc_target,
  input  logic            zero,
  output logic [2:0]      alu_op,
  output logic            alu_en,
  output logic [3:0]      reg_sel,
  output logic            avg_shift,
  output logic            busy,
  output logic            halted,
  output logic            illegal,
  output logic [CNTW-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_DECODE   = 3'd2,
    S_EXEC     = 3'd3,
    S_EXEC2    = 3'd4,
    S_OPERAND  = 3'd5,
`ifdef SINGLE_STEP_EN
    S_STEPWAIT = 3'd7,
`endif
    S_HALTED   = 3'd6
  } state_t;

  // Every path that would start a new fetch goes through this state.
`ifdef SINGLE_STEP_EN
  localparam state_t S_NEXT = S_STEPWAIT;
`else
  localparam state_t S_NEXT = S_FETCH;
`endif

  state_t    state;
  logic [7:0] ir;
  logic [3:0] opc;
  logic       take;

  assign opc  = ir[7:4];
  assign take = (opc == 4'h7) || zero;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state   <= S_IDLE;
      ir      <= 8'h00;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) state <= S_NEXT;
        end
        S_FETCH: begin
          if (mem_valid) begin
            ir    <= mem_data;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          case (opc)
            4'h0: begin
              state   <= S_NEXT;
              retired <= retired + CNTW'(1);
            end
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: state <= S_EXEC;
            4'h7, 4'h8: state <= S_OPERAND;
            4'hF: begin
              state   <= S_HALTED;
              retired <= retired + CNTW'(1);
            end
            default: begin
              illegal <= 1'b1;
              state   <= S_HALTED;
            end
          endcase
        end
        S_EXEC: begin
          if (opc == 4'h5) begin
            state <= S_EXEC2;
          end else begin
            state   <= S_NEXT;
            retired <= retired + CNTW'(1);
          end
        end
        S_EXEC2: begin
          state   <= S_NEXT;
          retired <= retired + CNTW'(1);
        end
        S_OPERAND: begin
          if (mem_valid) begin
            state   <= S_NEXT;
            retired <= retired + CNTW'(1);
          end
        end
        S_HALTED: state <= S_HALTED;
`ifdef SINGLE_STEP_EN
        S_STEPWAIT: begin
          if (step) state <= S_FETCH;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes are qualified by mem_valid so they fire only in the handshake cycle.
  always_comb begin
    mem_rd    = (state == S_FETCH) || (state == S_OPERAND);
    pc_inc    = mem_valid && ((state == S_FETCH) || ((state == S_OPERAND) && !take));
    pc_load   = mem_valid && (state == S_OPERAND) && take;
    pc_target = pc_load ? AW'(mem_data) : '0;
    alu_en    = (state == S_EXEC) || (state == S_EXEC2);
    alu_op    = alu_en ? ir[6:4] : 3'd0;
    avg_shift = (state == S_EXEC2);
    reg_sel   = ir[3:0];
    busy      = (state != S_IDLE) && (state != S_HALTED);
    halted    = (state == S_HALTED);
  end

endmodule

`default_nettype wire
